// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: instruction memory port, execute redirect and decode handshake.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    // Fetch unit side.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output fetch_fault
    );

    // Memory / execute / decode side.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order memory requests, response queue to decode,
// redirect/flush handling and a fault state for misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master fetch_io
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned SumW = CntW + 1;

    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [SumW-1:0] DepthLim = SumW'(DEPTH);

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e state_q, state_d;

    // active_q keeps the request port quiet in the first cycle out of reset.
    logic            active_q;
    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] out_q, out_d;      // requests accepted, response not yet seen
    logic [CntW-1:0] disc_q, disc_d;    // responses still to be dropped after a redirect
    logic [CntW-1:0] count_q, count_d;  // instruction queue occupancy

    // PC FIFO: one entry per outstanding request, popped by every response.
    logic [31:0]     pcq_mem_q [DEPTH];
    logic [PtrW-1:0] pcq_wr_q, pcq_wr_d;
    logic [PtrW-1:0] pcq_rd_q, pcq_rd_d;

    // Instruction queue towards decode.
    logic [31:0]     iq_data_q [DEPTH];
    logic [31:0]     iq_pc_q   [DEPTH];
    logic [PtrW-1:0] iq_wr_q, iq_wr_d;
    logic [PtrW-1:0] iq_rd_q, iq_rd_d;

    logic redirect, aligned, credit_ok;
    logic req_valid, inst_valid, fault;
    logic req_fire, resp_fire, drop, push, pop;

    assign redirect  = fetch_io.redirect_valid;
    assign aligned   = (fetch_io.redirect_pc[1:0] == 2'b00);
    // Reserve a queue slot for every in-flight request so a response always fits.
    assign credit_ok = ({1'b0, count_q} + {1'b0, out_q}) < DepthLim;

    assign req_fire  = req_valid && fetch_io.imem_req_ready;
    assign resp_fire = fetch_io.imem_resp_valid;
    // A response arriving alongside a redirect belongs to the old stream.
    assign drop      = redirect || (disc_q != '0) || (state_q == StFault);
    assign push      = resp_fire && !drop;
    assign pop       = inst_valid && fetch_io.inst_ready && !redirect;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any redirect decides RUN vs FAULT by target alignment.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = aligned ? StRun : StFault;
        end
    end

    // FSM outputs.
    always_comb begin
        req_valid  = 1'b0;
        inst_valid = 1'b0;
        fault      = 1'b0;
        unique case (state_q)
            StRun: begin
                req_valid  = active_q && !redirect && credit_ok;
                inst_valid = (count_q != '0);
            end
            StFault: begin
                fault = 1'b1;
            end
        endcase
    end

    // Next-state for PC, request accounting and queue pointers.
    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q + (req_fire ? CntOne : '0) - (resp_fire ? CntOne : '0);
        disc_d   = disc_q;
        pcq_wr_d = req_fire ? (pcq_wr_q + PtrOne) : pcq_wr_q;
        pcq_rd_d = resp_fire ? (pcq_rd_q + PtrOne) : pcq_rd_q;
        iq_wr_d  = push ? (iq_wr_q + PtrOne) : iq_wr_q;
        iq_rd_d  = pop ? (iq_rd_q + PtrOne) : iq_rd_q;
        count_d  = count_q + (push ? CntOne : '0) - (pop ? CntOne : '0);

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        if (redirect) begin
            // Everything still in flight after this cycle is stale.
            disc_d  = out_d;
            iq_wr_d = '0;
            iq_rd_d = '0;
            count_d = '0;
            if (aligned) begin
                pc_d = fetch_io.redirect_pc;
            end
        end else if (resp_fire && (disc_q != '0)) begin
            disc_d = disc_q - CntOne;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            pc_q     <= RESET_PC;
            out_q    <= '0;
            disc_q   <= '0;
            count_q  <= '0;
            pcq_wr_q <= '0;
            pcq_rd_q <= '0;
            iq_wr_q  <= '0;
            iq_rd_q  <= '0;
        end else begin
            active_q <= 1'b1;
            pc_q     <= pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            count_q  <= count_d;
            pcq_wr_q <= pcq_wr_d;
            pcq_rd_q <= pcq_rd_d;
            iq_wr_q  <= iq_wr_d;
            iq_rd_q  <= iq_rd_d;
        end
    end

    // Storage for request PCs and queued instruction/PC pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pcq_mem_q[i] <= '0;
                iq_data_q[i] <= '0;
                iq_pc_q[i]   <= '0;
            end
        end else begin
            if (req_fire) begin
                pcq_mem_q[pcq_wr_q] <= pc_q;
            end
            if (push) begin
                iq_data_q[iq_wr_q] <= fetch_io.imem_resp_data;
                iq_pc_q[iq_wr_q]   <= pcq_mem_q[pcq_rd_q];
            end
        end
    end

    assign fetch_io.imem_req_valid = req_valid;
    assign fetch_io.imem_req_addr  = pc_q;
    assign fetch_io.inst_valid     = inst_valid;
    assign fetch_io.inst           = inst_valid ? iq_data_q[iq_rd_q] : '0;
    assign fetch_io.inst_pc        = inst_valid ? iq_pc_q[iq_rd_q] : '0;
    assign fetch_io.fetch_fault    = fault;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with configurable latency, expected
// instruction PCs queued by the stimulus and checked by an independent monitor.
module tb_fetch_unit;
    localparam logic [31:0] RstPc = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC(RstPc),
        .DEPTH   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fetch_io(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];
    int          hs_cyc[$];
    mreq_t       mq[$];
    int          mem_lat = 1;
    bit          mem_toggle = 1'b0;
    bit          ready_en = 1'b0;
    bit          force_ready = 1'b0;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    function automatic logic [31:0] log_at(int i);
        return (i < req_log.size()) ? req_log[i] : 32'hBAD0_BAD0;
    endfunction

    function automatic int rcyc_at(int i);
        return (i < req_cyc.size()) ? req_cyc[i] : -1000;
    endfunction

    function automatic int hcyc_at(int i);
        return (i < hs_cyc.size()) ? hs_cyc[i] : -2000;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, want);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: decides the response and ready for the coming edge, logs requests.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
            bus.imem_req_ready  = 1'b1;
        end else begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = word_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = '0;
            end
            bus.imem_req_ready = mem_toggle ? ((cyc % 3) != 0) : 1'b1;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
                req_log.push_back(bus.imem_req_addr);
                req_cyc.push_back(cyc);
            end
        end
    end

    // Monitor: every accepted instruction is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_inst: got pc %h, required no instruction",
                         bus.inst_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("inst_pc", bus.inst_pc, e);
                check("inst_word", bus.inst, word_of(e));
            end
        end
    end

    task automatic upd_ready();
        bus.inst_ready = ready_en && (exp_q.size() > 0 || force_ready);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd_ready();
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic push_seq(logic [31:0] base, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
        upd_ready();
    endtask

    task automatic wait_drain(string name, int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        ready_en         = 1'b0;
        force_ready      = 1'b0;
        mem_toggle       = 1'b0;
        mem_lat          = 1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        upd_ready();
        #1;
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
        ticks(3);
        req_log.delete();
        req_cyc.delete();
        hs_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(logic [31:0] tgt);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        int n0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;

        // Reset values.
        ticks(2);
        check("reset_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("reset_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("reset_inst", bus.inst, 32'd0);
        check("reset_inst_pc", bus.inst_pc, 32'd0);
        check("reset_fetch_fault", 32'(bus.fetch_fault), 32'd0);

        // Streaming with 1-cycle memory.
        do_reset();
        ready_en = 1'b1;
        push_seq(RstPc, 8);
        wait_drain("p1", 60);
        check("p1_req0", log_at(0), 32'h0000_0100);
        check("p1_req1", log_at(1), 32'h0000_0104);
        check("p1_req2", log_at(2), 32'h0000_0108);
        check("p1_req_back_to_back", 32'(rcyc_at(7) - rcyc_at(0)), 32'd7);
        check("p1_fill_latency", 32'(hcyc_at(0) - rcyc_at(0)), 32'd2);
        check("p1_one_per_cycle", 32'(hcyc_at(7) - hcyc_at(0)), 32'd7);

        // Decode stalled: credit limit and stable head.
        do_reset();
        ticks(10);
        check("p2_req_count", 32'(req_log.size()), 32'd4);
        check("p2_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
        check("p2_head_valid", 32'(bus.inst_valid), 32'd1);
        check("p2_head_pc", bus.inst_pc, 32'h0000_0100);
        check("p2_head_word", bus.inst, word_of(32'h0000_0100));
        tick();
        check("p2_head_stable", bus.inst_pc, 32'h0000_0100);
        ready_en = 1'b1;
        push_seq(RstPc, 10);
        wait_drain("p2", 80);

        // 3-cycle memory, redirect with requests in flight.
        do_reset();
        mem_lat  = 3;
        ready_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_log.size() >= 3) break;
        end
        n0 = req_log.size();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2000;
        #1;
        check("p3_no_req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        push_seq(32'h0000_2000, 6);
        wait_drain("p3", 80);
        check("p3_first_req_after", log_at(n0), 32'h0000_2000);

        // Redirect colliding with a response and a decode pop.
        do_reset();
        ready_en = 1'b1;
        push_seq(RstPc, 2);
        wait_drain("p4_pre", 40);
        force_ready        = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0400;
        upd_ready();
        @(negedge clk);
        check("p4_head_valid_at_redirect", 32'(bus.inst_valid), 32'd1);
        check("p4_resp_at_redirect", 32'(bus.imem_resp_valid), 32'd1);
        tick();
        bus.redirect_valid = 1'b0;
        force_ready        = 1'b0;
        upd_ready();
        check("p4_flushed", 32'(bus.inst_valid), 32'd0);
        push_seq(32'h0000_0400, 4);
        wait_drain("p4", 40);

        // Misaligned redirect, fault hold, recovery.
        do_reset();
        ticks(4);
        redirect_to(32'h0000_2002);
        check("p5_fault_set", 32'(bus.fetch_fault), 32'd1);
        check("p5_inst_invalid", 32'(bus.inst_valid), 32'd0);
        n0 = req_log.size();
        ticks(5);
        check("p5_no_req_in_fault", 32'(req_log.size()), 32'(n0));
        check("p5_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
        redirect_to(32'h0000_2001);
        check("p5_fault_kept", 32'(bus.fetch_fault), 32'd1);
        n0 = req_log.size();
        redirect_to(32'h0000_3000);
        check("p5_fault_cleared", 32'(bus.fetch_fault), 32'd0);
        ready_en = 1'b1;
        push_seq(32'h0000_3000, 4);
        wait_drain("p5", 40);
        check("p5_first_req", log_at(n0), 32'h0000_3000);

        // PC wrap at the top of the address space.
        do_reset();
        ticks(3);
        redirect_to(32'hFFFF_FFF8);
        n0 = req_log.size();
        ready_en = 1'b1;
        push_seq(32'hFFFF_FFF8, 4);
        wait_drain("p6", 40);
        check("p6_req_fff8", log_at(n0), 32'hFFFF_FFF8);
        check("p6_req_fffc", log_at(n0 + 1), 32'hFFFF_FFFC);
        check("p6_req_wrap", log_at(n0 + 2), 32'h0000_0000);

        // Memory backpressure with 2-cycle latency.
        do_reset();
        mem_lat    = 2;
        mem_toggle = 1'b1;
        ready_en   = 1'b1;
        push_seq(RstPc, 8);
        wait_drain("p7", 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
